// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS32 fetch front end.
package mips_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  // All-zero word decodes as sll $0,$0,0 and serves as the pipeline bubble.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Ceiling log2; used to size the instruction memory word index.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/mips_imem_sync.sv
// Synchronous-read instruction memory with one write port. Neither the
// storage nor the read register is reset so the array maps onto block RAM.
module mips_imem_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read share the edge; a same-index collision
  // returns the pre-write word because both use non-blocking updates.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection, synchronous
// instruction memory, IF/ID valid bit and delivered-instruction counter.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int                   WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int                   IMEM_DEPTH = 1024,
  parameter logic [WORD_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic                              Stall_ID,
  input  logic                              Flush_ID,
  input  logic                              PCSrc_MEM,
  input  logic [WORD_WIDTH-1:0]             Branch_Dest_MEM,
  input  logic                              Imem_Wr_En,
  input  logic [clog2(IMEM_DEPTH)-1:0]      Imem_Wr_Addr,
  input  logic [WORD_WIDTH-1:0]             Imem_Wr_Data,
  output logic [WORD_WIDTH-1:0]             PC_IF,
  output logic [WORD_WIDTH-1:0]             Instruction_ID,
  output logic [WORD_WIDTH-1:0]             PC_Plus_4_ID,
  output logic                              Valid_ID,
  output logic [31:0]                       Fetch_Count
);

  localparam int AW = clog2(IMEM_DEPTH);

  logic                  advance;
  logic                  valid_next;
  logic [WORD_WIDTH-1:0] pc_plus_4;
  logic [WORD_WIDTH-1:0] pc_next;
  logic [WORD_WIDTH-1:0] imem_rd_data;

  // A taken branch must land even when ID is stalled, so it forces advance.
  assign advance   = !Stall_ID || PCSrc_MEM;
  assign pc_plus_4 = PC_IF + WORD_WIDTH'(4);

  // Next-PC priority: redirect, then hold on stall, then sequential.
  always_comb begin
    pc_next = pc_plus_4;
    if (PCSrc_MEM) pc_next = Branch_Dest_MEM & ~WORD_WIDTH'(3);
    else if (Stall_ID) pc_next = PC_IF;
  end

  // Valid bit: a redirect or flush kills the word entering ID; a flush
  // during a stall kills the held word instead.
  always_comb begin
    valid_next = Valid_ID && !Flush_ID;
    if (advance) valid_next = !(PCSrc_MEM || Flush_ID);
  end

  // PC, IF/ID metadata and counter; memory contents survive reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PC_IF        <= RESET_PC;
      Valid_ID     <= 1'b0;
      PC_Plus_4_ID <= '0;
      Fetch_Count  <= '0;
    end else begin
      PC_IF    <= pc_next;
      Valid_ID <= valid_next;
      if (advance) PC_Plus_4_ID <= pc_plus_4;
      if (advance && valid_next) Fetch_Count <= Fetch_Count + 32'd1;
    end
  end

  // Upper PC bits alias modulo the memory depth.
  mips_imem_sync #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk     (Clk),
    .rd_en   (advance),
    .rd_addr (PC_IF[AW+1:2]),
    .wr_en   (Imem_Wr_En),
    .wr_addr (Imem_Wr_Addr),
    .wr_data (Imem_Wr_Data),
    .rd_data (imem_rd_data)
  );

  // The read register is never reset, so the valid bit masks stale data.
  assign Instruction_ID = Valid_ID ? imem_rd_data : WORD_WIDTH'(MIPS_NOP);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: reference model plus directed literal checks.
module tb_mips_fetch_unit;

  localparam int DEPTH = 16;

  logic        Clk;
  logic        Rst_n;
  logic        Stall_ID, Flush_ID, PCSrc_MEM;
  logic [31:0] Branch_Dest_MEM;
  logic        Imem_Wr_En;
  logic [3:0]  Imem_Wr_Addr;
  logic [31:0] Imem_Wr_Data;
  logic [31:0] PC_IF, Instruction_ID, PC_Plus_4_ID, Fetch_Count;
  logic        Valid_ID;

  mips_fetch_unit #(
    .WORD_WIDTH (32),
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Stall_ID        (Stall_ID),
    .Flush_ID        (Flush_ID),
    .PCSrc_MEM       (PCSrc_MEM),
    .Branch_Dest_MEM (Branch_Dest_MEM),
    .Imem_Wr_En      (Imem_Wr_En),
    .Imem_Wr_Addr    (Imem_Wr_Addr),
    .Imem_Wr_Data    (Imem_Wr_Data),
    .PC_IF           (PC_IF),
    .Instruction_ID  (Instruction_ID),
    .PC_Plus_4_ID    (PC_Plus_4_ID),
    .Valid_ID        (Valid_ID),
    .Fetch_Count     (Fetch_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: what the ID stage must show, derived from the fetch rules.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_word, m_pc4, m_cnt;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_pc4   = 32'h0;
    m_cnt   = 32'h0;
  endtask

  // Every falling edge: DUT outputs must equal the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_pc_if", PC_IF, m_pc);
      chk("model_valid", {31'b0, Valid_ID}, {31'b0, m_valid});
      chk("model_instr", Instruction_ID, m_valid ? m_word : 32'h0);
      chk("model_pc4", PC_Plus_4_ID, m_pc4);
      chk("model_count", Fetch_Count, m_cnt);
    end
  end

  // One clock with the given controls; model advances with the edge.
  task automatic step(input logic stall, input logic flush, input logic pcsrc,
                      input logic [31:0] dest, input logic wen,
                      input logic [3:0] waddr, input logic [31:0] wdata);
    logic        move, n_valid;
    logic [31:0] n_pc, n_word, n_pc4, n_cnt;
    Stall_ID        = stall;
    Flush_ID        = flush;
    PCSrc_MEM       = pcsrc;
    Branch_Dest_MEM = dest;
    Imem_Wr_En      = wen;
    Imem_Wr_Addr    = waddr;
    Imem_Wr_Data    = wdata;
    move    = !stall || pcsrc;
    n_word  = m_word;
    n_pc4   = m_pc4;
    n_cnt   = m_cnt;
    n_valid = m_valid && !flush;
    if (move) begin
      n_word  = m_mem[(m_pc / 4) % DEPTH];
      n_pc4   = m_pc + 4;
      n_valid = !(pcsrc || flush);
      if (n_valid) n_cnt = m_cnt + 1;
    end
    if (pcsrc) n_pc = dest - (dest % 4);
    else if (stall) n_pc = m_pc;
    else n_pc = m_pc + 4;
    @(posedge Clk);
    #1;
    if (wen) m_mem[waddr] = wdata;
    if (Rst_n) begin
      m_pc = n_pc; m_word = n_word; m_pc4 = n_pc4; m_cnt = n_cnt; m_valid = n_valid;
    end
    Imem_Wr_En = 1'b0;
  endtask

  task automatic run();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b1;
    Stall_ID = 0; Flush_ID = 0; PCSrc_MEM = 0; Branch_Dest_MEM = 0;
    Imem_Wr_En = 0; Imem_Wr_Addr = 0; Imem_Wr_Data = 0;
    model_reset();
    m_word = 32'h0;
    #1 Rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Preload through the write port while reset is held.
    for (int i = 0; i < DEPTH; i++) begin
      Stall_ID = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'(i),
           (i < 4) ? 32'h2001_0001 + 32'(i) : 32'hA000_0000 + 32'(i));
    end
    Rst_n = 1'b1;
    chk("lit_first_valid", {31'b0, Valid_ID}, 32'h0);

    run();
    chk("lit_seq1_instr", Instruction_ID, 32'h2001_0001);
    chk("lit_seq1_pc4", PC_Plus_4_ID, 32'd4);
    run();
    chk("lit_seq2_instr", Instruction_ID, 32'h2001_0002);
    chk("lit_seq2_pc4", PC_Plus_4_ID, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      chk("lit_stall_instr", Instruction_ID, 32'h2001_0002);
      chk("lit_stall_pc", PC_IF, 32'd8);
      chk("lit_stall_count", Fetch_Count, 32'd2);
    end
    run();
    chk("lit_seq3_instr", Instruction_ID, 32'h2001_0003);
    chk("lit_seq3_pc4", PC_Plus_4_ID, 32'd12);
    run();
    chk("lit_seq4_instr", Instruction_ID, 32'h2001_0004);
    chk("lit_seq4_pc4", PC_Plus_4_ID, 32'd16);
    chk("lit_seq_count", Fetch_Count, 32'd4);

    // Redirect overrides stall; 0x40 aliases to index 0.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b0, 4'h0, 32'h0);
    chk("lit_redir_pc", PC_IF, 32'h40);
    chk("lit_redir_valid", {31'b0, Valid_ID}, 32'h0);
    chk("lit_redir_instr", Instruction_ID, 32'h0);
    run();
    chk("lit_redir_target", Instruction_ID, 32'h2001_0001);

    // Flush without stall, then with stall.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("lit_flush_valid", {31'b0, Valid_ID}, 32'h0);
    chk("lit_flush_pc", PC_IF, 32'h48);
    run();
    chk("lit_flush_next", Instruction_ID, 32'h2001_0003);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("lit_flstall_valid", {31'b0, Valid_ID}, 32'h0);
    chk("lit_flstall_pc", PC_IF, 32'h4C);
    run();
    chk("lit_flstall_next", Instruction_ID, 32'h2001_0004);
    chk("lit_flstall_pcif", PC_IF, 32'h50);

    // Alias: 0x44 reads index 1.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 4'h0, 32'h0);
    run();
    chk("lit_alias_instr", Instruction_ID, 32'h2001_0002);
    chk("lit_alias_count", Fetch_Count, 32'd8);

    // Load collision at index 5: old word first, new word on re-fetch.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h5, 32'hDEAD_BEEF);
    chk("lit_coll_old", Instruction_ID, 32'hA000_0005);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 4'h0, 32'h0);
    run();
    chk("lit_coll_new", Instruction_ID, 32'hDEAD_BEEF);
    chk("lit_coll_count", Fetch_Count, 32'd10);

    // Asynchronous reset between edges.
    #1;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit_arst_pc", PC_IF, 32'h0);
    chk("lit_arst_valid", {31'b0, Valid_ID}, 32'h0);
    chk("lit_arst_instr", Instruction_ID, 32'h0);
    chk("lit_arst_pc4", PC_Plus_4_ID, 32'h0);
    chk("lit_arst_count", Fetch_Count, 32'h0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    run();
    chk("lit_post_rst", Instruction_ID, 32'h2001_0001);
    chk("lit_post_rst_cnt", Fetch_Count, 32'd1);

    // Write accepted during a stall.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'h1, 32'h1234_5678);
    run();
    chk("lit_stall_write", Instruction_ID, 32'h1234_5678);

    // Mixed control traffic checked against the model only.
    for (int i = 0; i < 80; i++) begin
      step(($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
           32'($urandom_range(0, 127)), ($urandom % 4) == 0,
           4'($urandom), $urandom);
    end

    @(negedge Clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
